// File: rtl/watch_pkg.sv
// Shared types and constants for the watch timekeeping block.
// Set-mode states, BCD field limits and default clocking.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } set_state_t;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    localparam int unsigned DEF_IN_CLK_HZ   = 50_000_000;
    localparam int unsigned DEF_BLINK_HZ    = 2;
    localparam int unsigned DEF_AUTO_EXIT_S = 10;

    // Bits needed to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter wrapping to 00 after MAX.
// carry pulses with the increment that performs the wrap.
module bcd_wrap_counter
    import watch_pkg::*;
#(
    parameter int unsigned MAX = SEC_MAX
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_carry
);

    localparam logic [3:0] TENS_MAX = 4'(MAX / 10);
    localparam logic [3:0] ONES_MAX = 4'(MAX % 10);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       w_at_max;

    assign w_at_max = (r_tens == TENS_MAX) && (r_ones == ONES_MAX);
    assign o_carry  = i_inc && !i_clr && w_at_max;
    assign o_tens   = r_tens;
    assign o_ones   = r_ones;

    // Digit update: clear wins, then wrap at MAX, then decimal carry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (i_clr) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (i_inc) begin
            if (w_at_max) begin
                r_tens <= 4'd0;
                r_ones <= 4'd0;
            end else if (r_ones == 4'd9) begin
                r_tens <= r_tens + 4'd1;
                r_ones <= 4'd0;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/watch_time_set.sv
// Watch timekeeping with HH:MM set mode driven by key events.
// Drives four BCD digits and a blink mask for the field being edited.
module watch_time_set
    import watch_pkg::*;
#(
    parameter int unsigned IN_CLK_HZ   = DEF_IN_CLK_HZ,
    parameter int unsigned BLINK_HZ    = DEF_BLINK_HZ,
    parameter int unsigned AUTO_EXIT_S = DEF_AUTO_EXIT_S
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_first_1,
    input  logic       key_long_1,
    input  logic       key_first_2,
    input  logic       key_long_2,
    output logic [3:0] hex_0,
    output logic [3:0] hex_1,
    output logic [3:0] hex_2,
    output logic [3:0] hex_3,
    output logic [3:0] blank,
    output logic       edit_mode,
    output logic       sec_tick
);

    localparam int unsigned PW = cnt_width(IN_CLK_HZ);
    localparam logic [PW-1:0] PRESC_LAST = PW'(IN_CLK_HZ - 1);

    localparam int unsigned HALF_RAW = IN_CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned HALF = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int unsigned BW = cnt_width(HALF);
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

    localparam int unsigned IW = cnt_width(AUTO_EXIT_S);
    localparam logic [IW-1:0] IDLE_LAST = IW'(AUTO_EXIT_S - 1);

    set_state_t    r_state;
    set_state_t    w_state_nxt;
    logic [PW-1:0] r_presc;
    logic          r_sec_tick;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase_on;
    logic [IW-1:0] r_idle;
    logic [3:0]    w_blank;

    logic w_wrap;
    logic w_edit;
    logic w_ev_long2;
    logic w_ev_first2;
    logic w_ev_first1;
    logic w_any_key;
    logic w_timeout;
    logic w_enter_edit;
    logic w_exit_edit;
    logic w_run_tick;
    logic w_inc_hour_key;
    logic w_inc_min_key;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_min_inc;
    logic w_hour_inc;

    logic [3:0] w_unused_sec_tens;
    logic [3:0] w_unused_sec_ones;
    logic       w_unused_hour_carry;
    logic       w_unused_key_long_1;

    // Long press of key 1 has no function here.
    assign w_unused_key_long_1 = key_long_1;

    // Only the highest-priority event of a cycle is acted on.
    assign w_ev_long2  = key_long_2;
    assign w_ev_first2 = key_first_2 && !key_long_2;
    assign w_ev_first1 = key_first_1 && !key_first_2 && !key_long_2;
    assign w_any_key   = key_first_1 || key_first_2 || key_long_2;

    assign w_wrap = (r_presc == PRESC_LAST);
    assign w_edit = (r_state != RUN);

    assign w_timeout = w_edit && w_wrap && !w_any_key
                    && (r_idle == IDLE_LAST);

    // Next-state decode for the set-mode FSM.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (w_ev_long2) w_state_nxt = SET_HOUR;
            end
            SET_HOUR: begin
                if (w_ev_long2)       w_state_nxt = RUN;
                else if (w_ev_first2) w_state_nxt = SET_MIN;
                else if (w_timeout)   w_state_nxt = RUN;
            end
            SET_MIN: begin
                if (w_ev_long2 || w_ev_first2 || w_timeout)
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_enter_edit = (w_state_nxt != RUN)
                       && (w_state_nxt != r_state);
    assign w_exit_edit  = w_edit && (w_state_nxt == RUN);

    assign w_run_tick     = (r_state == RUN) && w_wrap;
    assign w_inc_hour_key = (r_state == SET_HOUR) && w_ev_first1;
    assign w_inc_min_key  = (r_state == SET_MIN) && w_ev_first1;

    // Minute carries into the hour only while the clock is running.
    assign w_min_inc  = w_sec_carry || w_inc_min_key;
    assign w_hour_inc = ((r_state == RUN) && w_min_carry)
                     || w_inc_hour_key;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // Free-running 1 s prescaler and registered tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
        end else begin
            r_presc    <= w_wrap ? '0 : r_presc + 1'b1;
            r_sec_tick <= w_wrap;
        end
    end

    // Blink phase: restart visible on entry and after each increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (!w_edit || w_enter_edit
                     || w_inc_hour_key || w_inc_min_key) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase_on  <= !r_phase_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Idle seconds in an edit state; any key restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (!w_edit || w_enter_edit
                     || w_any_key || w_timeout) begin
            r_idle <= '0;
        end else if (w_wrap) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    // Blank the edited field during the off phase.
    always_comb begin
        w_blank = 4'b0000;
        if (!r_phase_on) begin
            if (r_state == SET_HOUR)     w_blank = 4'b1100;
            else if (r_state == SET_MIN) w_blank = 4'b0011;
        end
    end

    bcd_wrap_counter #(.MAX(SEC_MAX)) u_sec (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (w_run_tick),
        .i_clr   (w_exit_edit),
        .o_tens  (w_unused_sec_tens),
        .o_ones  (w_unused_sec_ones),
        .o_carry (w_sec_carry)
    );

    bcd_wrap_counter #(.MAX(MIN_MAX)) u_min (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (w_min_inc),
        .i_clr   (1'b0),
        .o_tens  (hex_1),
        .o_ones  (hex_0),
        .o_carry (w_min_carry)
    );

    bcd_wrap_counter #(.MAX(HOUR_MAX)) u_hour (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (w_hour_inc),
        .i_clr   (1'b0),
        .o_tens  (hex_3),
        .o_ones  (hex_2),
        .o_carry (w_unused_hour_carry)
    );

    assign blank     = w_blank;
    assign edit_mode = w_edit;
    assign sec_tick  = r_sec_tick;

endmodule
